// File: rtl/rename_reg_file.sv
// ---------------------------------------------------------------------------
// rename_reg_file
//
// Architectural register file with a per-register rename label. Each of the
// REG_NUM registers holds its committed value plus the ROB tag of the youngest
// in-flight instruction that will write it (label 0 = value is final).
// Sits directly upstream of the reorder buffer: supplies source operands and
// labels to the instruction being issued, records the destination's new tag,
// retires committed results and drops every label on a flush.
//
// Ports
//   clk          system clock, all state changes on the rising edge
//   rst_in       asynchronous active-low reset
//   rdy_in       global enable; low freezes all state
//   rs1, rs2     source register indices of the issuing instruction
//   val1, val2   committed value of rs1 / rs2 (with commit bypass)
//   label1/2     pending ROB tag of rs1 / rs2, 0 when the value is final
//   issue_en     an instruction with a destination issues this cycle
//   issue_rd     its destination register
//   issue_tag    ROB tag allocated to it (never 0)
//   commit_en    ROB retires a register-writing instruction
//   commit_rd    destination of the retiring instruction
//   commit_res   its result value
//   commit_lab   its ROB tag
//   flush        misprediction flush: clear all labels
//   pending_cnt  number of registers currently carrying a nonzero label
//
// Handshake: there is no per-port valid/ready pair. issue_en and commit_en
// act as valids that are always accepted on a rising edge where rdy_in is
// high; when rdy_in is low nothing is accepted and the presenter must hold
// its request. Read ports are pure combinational lookups.
// ---------------------------------------------------------------------------
module rename_reg_file #(
    parameter int REG_NUM      = 32,
    parameter int REG_WIDTH    = 5,
    parameter int VAL_WIDTH    = 32,
    parameter int ROB_ID_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_in,
    input  logic                    rdy_in,

    input  logic [REG_WIDTH-1:0]    rs1,
    input  logic [REG_WIDTH-1:0]    rs2,
    output logic [VAL_WIDTH-1:0]    val1,
    output logic [VAL_WIDTH-1:0]    val2,
    output logic [ROB_ID_WIDTH:0]   label1,
    output logic [ROB_ID_WIDTH:0]   label2,

    input  logic                    issue_en,
    input  logic [REG_WIDTH-1:0]    issue_rd,
    input  logic [ROB_ID_WIDTH:0]   issue_tag,

    input  logic                    commit_en,
    input  logic [REG_WIDTH-1:0]    commit_rd,
    input  logic [VAL_WIDTH-1:0]    commit_res,
    input  logic [ROB_ID_WIDTH:0]   commit_lab,

    input  logic                    flush,
    output logic [REG_WIDTH:0]      pending_cnt
);

    localparam int LAB_W = ROB_ID_WIDTH + 1;
    localparam int CNT_W = REG_WIDTH + 1;

    // Committed values and rename labels. Entry 0 is never written, so x0
    // stays zero; reads of index 0 are forced to zero as well.
    logic [VAL_WIDTH-1:0] val_q [REG_NUM];
    logic [LAB_W-1:0]     lab_q [REG_NUM];
    logic [CNT_W-1:0]     cnt_q;

    // -----------------------------------------------------------------------
    // Qualified events for this edge
    // -----------------------------------------------------------------------
    logic             issue_act;
    logic             commit_act;
    logic             commit_match;
    logic             same_rd;
    logic [LAB_W-1:0] issue_old_lab;
    logic [LAB_W-1:0] commit_old_lab;
    logic             cnt_inc;
    logic             cnt_dec;
    logic [CNT_W-1:0] cnt_d;

    assign issue_act      = rdy_in && issue_en && !flush && (issue_rd != '0);
    assign commit_act     = rdy_in && commit_en && (commit_rd != '0);
    assign issue_old_lab  = lab_q[issue_rd];
    assign commit_old_lab = lab_q[commit_rd];
    // Clear a label only when the retiring tag is still the youngest producer;
    // a younger rename of the same register must survive the commit.
    assign commit_match   = commit_act && (commit_old_lab == commit_lab);
    assign same_rd        = issue_act && (issue_rd == commit_rd);

    // Pending count moves with the label transitions of this edge:
    // +1 when an issue renames a register that had no label,
    // -1 when a commit clears a nonzero label that an issue does not replace.
    assign cnt_inc = issue_act && (issue_old_lab == '0);
    assign cnt_dec = commit_match && (commit_old_lab != '0) && !same_rd;

    always_comb begin
        cnt_d = cnt_q;
        if (flush) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_q + CNT_W'(cnt_inc) - CNT_W'(cnt_dec);
        end
    end

    // -----------------------------------------------------------------------
    // State update
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_in) begin
        if (!rst_in) begin
            for (int i = 0; i < REG_NUM; i++) begin
                val_q[i] <= '0;
                lab_q[i] <= '0;
            end
            cnt_q <= '0;
        end else if (rdy_in) begin
            // Committed values are written even during a flush: the
            // retiring instruction is older than the mispredicted branch.
            if (commit_act) begin
                val_q[commit_rd] <= commit_res;
            end
            if (flush) begin
                for (int i = 0; i < REG_NUM; i++) begin
                    lab_q[i] <= '0;
                end
            end else begin
                if (commit_match) begin
                    lab_q[commit_rd] <= '0;
                end
                // Placed after the commit clear so a same-register issue wins.
                if (issue_act) begin
                    lab_q[issue_rd] <= issue_tag;
                end
            end
            cnt_q <= cnt_d;
        end
    end

    assign pending_cnt = cnt_q;

    // -----------------------------------------------------------------------
    // Read ports with commit bypass. Reads see pre-edge state, so the issuing
    // instruction's own destination rename never affects its sources.
    // -----------------------------------------------------------------------
    always_comb begin
        val1   = '0;
        label1 = '0;
        if (rs1 != '0) begin
            val1   = val_q[rs1];
            label1 = lab_q[rs1];
            if (commit_act && (commit_rd == rs1) && (lab_q[rs1] == commit_lab)) begin
                val1   = commit_res;
                label1 = '0;
            end
        end
    end

    always_comb begin
        val2   = '0;
        label2 = '0;
        if (rs2 != '0) begin
            val2   = val_q[rs2];
            label2 = lab_q[rs2];
            if (commit_act && (commit_rd == rs2) && (lab_q[rs2] == commit_lab)) begin
                val2   = commit_res;
                label2 = '0;
            end
        end
    end

endmodule

// File: doc/rename_reg_file.md
# rename_reg_file

Architectural register file with per-register rename labels; sits directly upstream of the reorder buffer. Holds 32 committed register values plus, per register, the ROB tag of the youngest in-flight producer. Supplies source operands and labels for the instruction being issued and tags its destination with the new ROB tag. Retires values written back by ROB commit and drops all speculative labels on flush.

## Interface
Parameters:
- REG_NUM, 32, number of architectural registers (x0 hard-wired zero)
- REG_WIDTH, 5, register index width
- VAL_WIDTH, 32, data width
- ROB_ID_WIDTH, 3, ROB index width; labels are ROB_ID_WIDTH+1 bits, value 0 = "no pending producer", valid tags 1..2^ROB_ID_WIDTH

Ports:
- clk  in  1  system clock, all state updates on rising edge
- rst_in  in  1  reset, asynchronous, active-low
- rdy_in  in  1  global enable; low freezes all state
- rs1, rs2  in  REG_WIDTH  source register indices of instruction at issue
- val1, val2  out  VAL_WIDTH  committed value of rs1/rs2 (with commit bypass)
- label1, label2  out  ROB_ID_WIDTH+1  pending ROB tag of rs1/rs2, 0 if value is final
- issue_en  in  1  decoder issues an instruction with a destination this cycle
- issue_rd  in  REG_WIDTH  destination register of issued instruction
- issue_tag  in  ROB_ID_WIDTH+1  ROB tag allocated to it (never 0)
- commit_en  in  1  ROB retires a register-writing instruction
- commit_rd  in  REG_WIDTH  destination of retired instruction
- commit_res  in  VAL_WIDTH  result value
- commit_lab  in  ROB_ID_WIDTH+1  ROB tag of retired instruction
- flush  in  1  misprediction flush from ROB
- pending_cnt  out  REG_WIDTH+1  number of registers with nonzero label

## Operation
- Storage: val[0..31], lab[0..31]. x0: val and lab read as 0 always; writes to index 0 ignored.
- Read (combinational): label1 = lab[rs1]; val1 = val[rs1]. Bypass: if commit_en && rdy_in && commit_rd==rs1 && rs1!=0 && lab[rs1]==commit_lab, then val1=commit_res and label1=0. Same for port 2. Reads reflect pre-issue state (an instruction's own rd rename never affects its sources).
- Issue: on edge with rdy_in && issue_en && !flush && issue_rd!=0: lab[issue_rd] <= issue_tag.
- Commit: on edge with rdy_in && commit_en && commit_rd!=0: val[commit_rd] <= commit_res; lab[commit_rd] <= 0 only if lab[commit_rd]==commit_lab (a younger producer keeps its label).
- Same-cycle issue and commit to same rd: value written, label = issue_tag (issue wins).
- Flush: on edge with rdy_in && flush: all lab <= 0; issue ignored; commit value in the same cycle still written.
- pending_cnt: registered count of nonzero labels, updated same edge as labels (increment on label 0->nonzero, decrement on nonzero->0, net for simultaneous events; 0 on flush).
- rdy_in low: no state change; combinational outputs still valid.

## Timing
- Reset (rst_in low, async): all val=0, all lab=0, pending_cnt=0; outputs val1/val2/label1/label2 = 0 immediately.
- Read latency 0 cycles (combinational); write/label update visible on outputs the cycle after the edge.
- Commit bypass makes a retiring value visible in the same cycle it is presented.
- Reset asserted mid-operation discards all state; first edge after release accepts issue/commit normally.
- Label wrap-around handled by ROB; tag reuse after retirement is safe because commit clears only on exact tag match.

## Test plan
- Reset, read rs1=5,rs2=0 -> val1=0,label1=0,val2=0,label2=0, pending_cnt=0.
- Issue rd=3 tag=2; next cycle read rs1=3 -> label1=2; commit rd=3 lab=2 res=0xDEADBEEF -> same-cycle val1=0xDEADBEEF,label1=0; next cycle lab[3]=0, pending_cnt=0.
- Issue rd=4 tag=1, then rd=4 tag=5; commit rd=4 lab=1 res=7 -> val[4]=7, label stays 5, pending_cnt=1.
- Same cycle issue rd=6 tag=3 and commit rd=6 lab=1 (lab[6]=1) res=9 -> val[6]=9, lab[6]=3.
- Labels on x1,x2,x7; flush with issue rd=8 tag=4 and commit rd=1 res=11 -> all labels 0, val[1]=11, lab[8]=0, pending_cnt=0.
- Issue/commit to rd=0 -> x0 stays 0/label 0; rdy_in low during issue rd=9 -> lab[9] unchanged.
